// File: rtl/kv_pkg.sv
// Shared opcode, op/error encodings and FSM states for the key/value frame assembler.
// KV_CHECKSUM_EN adds the trailing-checksum state.
package kv_pkg;

  localparam logic [7:0] OPC_CREATE = 8'h01;
  localparam logic [7:0] OPC_UPDATE = 8'h02;
  localparam logic [7:0] OPC_DELETE = 8'h03;

  localparam logic [1:0] OP_NONE   = 2'd0;
  localparam logic [1:0] OP_CREATE = 2'd1;
  localparam logic [1:0] OP_UPDATE = 2'd2;
  localparam logic [1:0] OP_DELETE = 2'd3;

  localparam logic [1:0] ERR_NONE       = 2'd0;
  localparam logic [1:0] ERR_BAD_OPCODE = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT    = 2'd2;
  localparam logic [1:0] ERR_CHECKSUM   = 2'd3;

`ifdef KV_CHECKSUM_EN
  typedef enum logic [1:0] {ST_IDLE, ST_KEY, ST_VALUE, ST_CSUM} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_KEY, ST_VALUE} state_t;
`endif

  // OP_NONE marks an opcode byte that does not start a frame.
  function automatic logic [1:0] decode_op(input logic [7:0] opc);
    case (opc)
      OPC_CREATE: return OP_CREATE;
      OPC_UPDATE: return OP_UPDATE;
      OPC_DELETE: return OP_DELETE;
      default:    return OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/kv_timeout_ctr.sv
// Inter-byte idle counter: cleared on load/idle, held while frozen, flags when LIMIT is reached.
// LIMIT = 0 keeps the counter at zero and never expires.
module kv_timeout_ctr #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  input  logic freeze,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 2);
  localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

  logic [CW-1:0] cnt_reg, cnt_next;

  assign expired = (LIMIT != 0) && (cnt_reg == LIMIT_C);

  always_comb begin
    cnt_next = cnt_reg;
    if (!run || clear) begin
      cnt_next = '0;
    end else if (!freeze && cnt_reg != LIMIT_C) begin
      cnt_next = cnt_reg + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_reg <= '0;
    else        cnt_reg <= cnt_next;
  end

endmodule

// File: rtl/kv_frame_assembler.sv
// Assembles opcode/key/value frames from a byte stream into a single-entry valid/ready output.
// Define KV_CHECKSUM_EN to require a trailing XOR checksum byte on every frame.
module kv_frame_assembler
  import kv_pkg::*;
#(
  parameter int KEY_BYTES      = 4,
  parameter int VAL_BYTES      = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic                   tick_in,
  input  logic                   rst_n,
  input  logic [7:0]             byte_in,
  input  logic                   byte_valid,
  output logic                   byte_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [1:0]             out_op,
  output logic [8*KEY_BYTES-1:0] out_key,
  output logic [8*VAL_BYTES-1:0] out_value,
  output logic                   err_pulse,
  output logic [1:0]             err_code,
  output logic [CNT_W-1:0]       frame_cnt
);

  localparam int KEY_W = 8 * KEY_BYTES;
  localparam int VAL_W = 8 * VAL_BYTES;
  localparam logic [3:0] KEY_LAST = 4'(KEY_BYTES - 1);
  localparam logic [3:0] VAL_LAST = 4'(VAL_BYTES - 1);

  state_t             state_reg, state_next;
  logic [3:0]         idx_reg, idx_next;
  logic [1:0]         op_reg, op_next;
  logic [KEY_W-1:0]   key_reg, key_next;
  logic [VAL_W-1:0]   val_reg, val_next;
  logic               out_valid_reg, out_valid_next;
  logic [1:0]         out_op_reg, out_op_next;
  logic [KEY_W-1:0]   out_key_reg, out_key_next;
  logic [VAL_W-1:0]   out_value_reg, out_value_next;
  logic               err_pulse_reg, err_pulse_next;
  logic [1:0]         err_code_reg, err_code_next;
  logic [CNT_W-1:0]   frame_cnt_reg, frame_cnt_next;
`ifdef KV_CHECKSUM_EN
  logic [7:0]         csum_reg, csum_next;
`endif

  logic             is_final, stall, accept, expired, deliver;
  logic [1:0]       dec_op;
  logic [KEY_W-1:0] key_shift;
  logic [VAL_W-1:0] val_shift;

  assign dec_op    = decode_op(byte_in);
  assign key_shift = KEY_W'({key_reg, byte_in});
  assign val_shift = VAL_W'({val_reg, byte_in});

`ifdef KV_CHECKSUM_EN
  assign is_final = (state_reg == ST_CSUM);
`else
  assign is_final = (state_reg == ST_KEY && idx_reg == KEY_LAST && op_reg == OP_DELETE) ||
                    (state_reg == ST_VALUE && idx_reg == VAL_LAST);
`endif

  // Hold the frame-completing byte back only while the output register cannot be freed.
  assign stall      = is_final && out_valid_reg && !out_ready;
  assign byte_ready = !stall && !expired;
  assign accept     = byte_valid && byte_ready;

  kv_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (tick_in),
    .rst_n   (rst_n),
    .run     (state_reg != ST_IDLE),
    .clear   (accept),
    .freeze  (stall),
    .expired (expired)
  );

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    op_next        = op_reg;
    key_next       = key_reg;
    val_next       = val_reg;
    out_valid_next = out_valid_reg;
    out_op_next    = out_op_reg;
    out_key_next   = out_key_reg;
    out_value_next = out_value_reg;
    err_pulse_next = 1'b0;
    err_code_next  = err_code_reg;
    frame_cnt_next = frame_cnt_reg;
    deliver        = 1'b0;
`ifdef KV_CHECKSUM_EN
    csum_next      = csum_reg;
`endif

    if (expired) begin
      state_next     = ST_IDLE;
      idx_next       = '0;
      err_pulse_next = 1'b1;
      err_code_next  = ERR_TIMEOUT;
    end else if (accept) begin
`ifdef KV_CHECKSUM_EN
      csum_next = csum_reg ^ byte_in;
`endif
      case (state_reg)
        ST_IDLE: begin
          op_next  = dec_op;
          idx_next = '0;
`ifdef KV_CHECKSUM_EN
          csum_next = byte_in;
`endif
          if (dec_op == OP_NONE) begin
            err_pulse_next = 1'b1;
            err_code_next  = ERR_BAD_OPCODE;
          end else begin
            state_next = ST_KEY;
          end
        end
        ST_KEY: begin
          key_next = key_shift;
          if (idx_reg == KEY_LAST) begin
            idx_next = '0;
            if (op_reg == OP_DELETE) begin
`ifdef KV_CHECKSUM_EN
              state_next = ST_CSUM;
`else
              state_next = ST_IDLE;
              deliver    = 1'b1;
`endif
            end else begin
              state_next = ST_VALUE;
            end
          end else begin
            idx_next = idx_reg + 4'd1;
          end
        end
        ST_VALUE: begin
          val_next = val_shift;
          if (idx_reg == VAL_LAST) begin
            idx_next = '0;
`ifdef KV_CHECKSUM_EN
            state_next = ST_CSUM;
`else
            state_next = ST_IDLE;
            deliver    = 1'b1;
`endif
          end else begin
            idx_next = idx_reg + 4'd1;
          end
        end
`ifdef KV_CHECKSUM_EN
        ST_CSUM: begin
          state_next = ST_IDLE;
          if (byte_in == csum_reg) begin
            deliver = 1'b1;
          end else begin
            err_pulse_next = 1'b1;
            err_code_next  = ERR_CHECKSUM;
          end
        end
`endif
        default: state_next = ST_IDLE;
      endcase
    end

    // key_next/val_next already include the byte accepted this cycle.
    if (deliver) begin
      out_valid_next = 1'b1;
      out_op_next    = op_reg;
      out_key_next   = key_next;
      out_value_next = (op_reg == OP_DELETE) ? '0 : val_next;
      frame_cnt_next = frame_cnt_reg + CNT_W'(1);
    end else if (out_valid_reg && out_ready) begin
      out_valid_next = 1'b0;
    end
  end

  always_ff @(posedge tick_in or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      idx_reg       <= '0;
      op_reg        <= OP_NONE;
      key_reg       <= '0;
      val_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_op_reg    <= OP_NONE;
      out_key_reg   <= '0;
      out_value_reg <= '0;
      err_pulse_reg <= 1'b0;
      err_code_reg  <= ERR_NONE;
      frame_cnt_reg <= '0;
`ifdef KV_CHECKSUM_EN
      csum_reg      <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      op_reg        <= op_next;
      key_reg       <= key_next;
      val_reg       <= val_next;
      out_valid_reg <= out_valid_next;
      out_op_reg    <= out_op_next;
      out_key_reg   <= out_key_next;
      out_value_reg <= out_value_next;
      err_pulse_reg <= err_pulse_next;
      err_code_reg  <= err_code_next;
      frame_cnt_reg <= frame_cnt_next;
`ifdef KV_CHECKSUM_EN
      csum_reg      <= csum_next;
`endif
    end
  end

  assign out_valid = out_valid_reg;
  assign out_op    = out_op_reg;
  assign out_key   = out_key_reg;
  assign out_value = out_value_reg;
  assign err_pulse = err_pulse_reg;
  assign err_code  = err_code_reg;
  assign frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_kv_frame_assembler.sv
// Self-checking bench for kv_frame_assembler (4-byte key/value, 8-cycle timeout).
// Builds frames from field values; appends the XOR checksum when KV_CHECKSUM_EN is defined.
module tb_kv_frame_assembler;

  localparam int KB = 4;
  localparam int VB = 4;
  localparam int TO = 8;
  localparam int CW = 16;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] key;
    logic [31:0] value;
  } frame_t;

  logic          tick_in = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    byte_in = 8'h00;
  logic          byte_valid = 1'b0;
  logic          byte_ready;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [1:0]    out_op;
  logic [31:0]   out_key;
  logic [31:0]   out_value;
  logic          err_pulse;
  logic [1:0]    err_code;
  logic [CW-1:0] frame_cnt;

  int            tests_run = 0;
  int            tests_failed = 0;
  logic [CW-1:0] exp_cnt = '0;
  logic [7:0]    tx_q[$];
  frame_t        got_q[$];
  logic [1:0]    err_q[$];

  kv_frame_assembler #(
    .KEY_BYTES(KB), .VAL_BYTES(VB), .TIMEOUT_CYCLES(TO), .CNT_W(CW)
  ) dut (
    .tick_in(tick_in), .rst_n(rst_n), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_key(out_key), .out_value(out_value), .err_pulse(err_pulse), .err_code(err_code),
    .frame_cnt(frame_cnt)
  );

  always #5 tick_in = ~tick_in;

  // Records output handshakes and error pulses just before each rising edge.
  always @(negedge tick_in) begin
    #3;
    if (rst_n && out_valid && out_ready) begin
      got_q.push_back({out_op, out_key, out_value});
      $display("[TB] out op=%0d key=%h value=%h", out_op, out_key, out_value);
    end
    if (rst_n && err_pulse) begin
      err_q.push_back(err_code);
      $display("[TB] err code=%0d", err_code);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic frame_t expect_frame(input logic [7:0] opc, input logic [31:0] k,
                                          input logic [31:0] v);
    frame_t f;
    f.op    = opc[1:0];
    f.key   = k;
    f.value = (opc == 8'h03) ? 32'h0 : v;
    return f;
  endfunction

  task automatic build_frame(input logic [7:0] opc, input logic [31:0] k, input logic [31:0] v);
    tx_q.delete();
    tx_q.push_back(opc);
    for (int i = KB - 1; i >= 0; i--) tx_q.push_back(k[8*i +: 8]);
    if (opc != 8'h03) for (int i = VB - 1; i >= 0; i--) tx_q.push_back(v[8*i +: 8]);
`ifdef KV_CHECKSUM_EN
    begin : csum_blk
      logic [7:0] x;
      x = 8'h00;
      foreach (tx_q[i]) x ^= tx_q[i];
      tx_q.push_back(x);
    end
`endif
  endtask

  // Offers one byte until accepted; returns on the falling edge after the accepting edge.
  task automatic put_byte(input logic [7:0] b);
    bit done;
    done = 0;
    byte_in = b;
    byte_valid = 1'b1;
    for (int t = 0; t < 400 && !done; t++) begin
      #1;
      if (byte_ready) done = 1;
      @(negedge tick_in);
    end
    byte_valid = 1'b0;
    if (!done) begin
      tests_run++;
      tests_failed++;
      $display("FAIL byte_accept byte=%h never accepted within 400 cycles", b);
    end
  endtask

  task automatic send_all(input int gap_max);
    while (tx_q.size() > 0) begin
      put_byte(tx_q.pop_front());
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge tick_in);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge tick_in);
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    tests_run++;
    if ({out_op, out_key, out_value} !== 66'h0) begin
      tests_failed++; $display("FAIL reset_out_fields got=%h exp=0", {out_op, out_key, out_value});
    end
    tests_run++;
    if ({err_pulse, err_code} !== 3'b0) begin
      tests_failed++; $display("FAIL reset_err got=%b exp=000", {err_pulse, err_code});
    end
    tests_run++;
    if (frame_cnt !== '0) begin tests_failed++; $display("FAIL reset_frame_cnt got=%0d exp=0", frame_cnt); end
    @(negedge tick_in);
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (byte_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_byte_ready got=%b exp=1", byte_ready); end
    @(negedge tick_in);
  endtask

  task automatic test_create;
    out_ready = 1'b1;
    build_frame(8'h01, 32'hDEADBEEF, 32'h0000002A);
    while (tx_q.size() > 1) put_byte(tx_q.pop_front());
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL create_early_valid got=%b exp=0", out_valid); end
    put_byte(tx_q.pop_front());
    exp_cnt++;
    tests_run++;
    if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL create_latency out_valid got=%b exp=1", out_valid); end
    tests_run++;
    if ({out_op, out_key, out_value} !== {2'd1, 32'hDEADBEEF, 32'h0000002A}) begin
      tests_failed++; $display("FAIL create_fields got=%h exp=%h", {out_op, out_key, out_value},
                               {2'd1, 32'hDEADBEEF, 32'h0000002A});
    end
    tests_run++;
    if (frame_cnt !== exp_cnt) begin tests_failed++; $display("FAIL create_cnt got=%0d exp=%0d", frame_cnt, exp_cnt); end
    @(negedge tick_in);
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL create_consume out_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_delete;
    frame_t e;
    out_ready = 1'b1;
    build_frame(8'h03, 32'h00000007, 32'hFFFFFFFF);
    send_all(0);
    exp_cnt++;
    e = expect_frame(8'h03, 32'h00000007, 32'hFFFFFFFF);
    tests_run++;
    if (out_valid !== 1'b1 || {out_op, out_key, out_value} !== e) begin
      tests_failed++; $display("FAIL delete_fields got=%b/%h exp=1/%h", out_valid, {out_op, out_key, out_value}, e);
    end
    build_frame(8'h01, 32'h11223344, 32'h55667788);
    send_all(0);
    exp_cnt++;
    e = expect_frame(8'h01, 32'h11223344, 32'h55667788);
    tests_run++;
    if ({out_op, out_key, out_value} !== e) begin
      tests_failed++; $display("FAIL delete_next_opcode got=%h exp=%h", {out_op, out_key, out_value}, e);
    end
    tests_run++;
    if (frame_cnt !== exp_cnt) begin tests_failed++; $display("FAIL delete_cnt got=%0d exp=%0d", frame_cnt, exp_cnt); end
    @(negedge tick_in);
  endtask

  task automatic test_bad_opcode;
    frame_t e;
    out_ready = 1'b1;
    @(negedge tick_in);
    put_byte(8'h55);
    tests_run++;
    if ({err_pulse, err_code, out_valid} !== 4'b1010) begin
      tests_failed++; $display("FAIL badop_err pulse/code/valid got=%b exp=1010", {err_pulse, err_code, out_valid});
    end
    @(negedge tick_in);
    tests_run++;
    if ({err_pulse, err_code} !== 3'b001) begin
      tests_failed++; $display("FAIL badop_pulse_width pulse/code got=%b exp=001", {err_pulse, err_code});
    end
    build_frame(8'h01, 32'hCAFEF00D, 32'h01020304);
    send_all(0);
    exp_cnt++;
    e = expect_frame(8'h01, 32'hCAFEF00D, 32'h01020304);
    tests_run++;
    if ({out_op, out_key, out_value} !== e) begin
      tests_failed++; $display("FAIL badop_recover got=%h exp=%h", {out_op, out_key, out_value}, e);
    end
    @(negedge tick_in);
  endtask

  task automatic test_back_pressure;
    frame_t a, b;
    logic [7:0] last;
    out_ready = 1'b0;
    a = expect_frame(8'h02, 32'hA1A2A3A4, 32'hB1B2B3B4);
    b = expect_frame(8'h02, 32'hC1C2C3C4, 32'hD1D2D3D4);
    build_frame(8'h02, 32'hA1A2A3A4, 32'hB1B2B3B4);
    send_all(0);
    exp_cnt++;
    got_q.delete();
    build_frame(8'h02, 32'hC1C2C3C4, 32'hD1D2D3D4);
    while (tx_q.size() > 1) put_byte(tx_q.pop_front());
    last = tx_q.pop_front();
    byte_in = last;
    byte_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      tests_run++;
      if (byte_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_stall cycle=%0d byte_ready got=%b exp=0", i, byte_ready); end
      tests_run++;
      if ({out_valid, err_pulse, out_op, out_key, out_value} !== {2'b10, a}) begin
        tests_failed++; $display("FAIL bp_hold cycle=%0d got=%h exp=%h", i,
                                 {out_valid, err_pulse, out_op, out_key, out_value}, {2'b10, a});
      end
      @(negedge tick_in);
    end
    out_ready = 1'b1;
    #1;
    tests_run++;
    if (byte_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_release byte_ready got=%b exp=1", byte_ready); end
    @(negedge tick_in);
    out_ready = 1'b0;
    byte_valid = 1'b0;
    exp_cnt++;
    tests_run++;
    if (out_valid !== 1'b1 || {out_op, out_key, out_value} !== b) begin
      tests_failed++; $display("FAIL bp_second got=%b/%h exp=1/%h", out_valid, {out_op, out_key, out_value}, b);
    end
    tests_run++;
    if (got_q.size() != 1 || got_q[0] !== a) begin
      tests_failed++; $display("FAIL bp_first_delivered count=%0d exp=1 frame %h", got_q.size(), a);
    end
    tests_run++;
    if (frame_cnt !== exp_cnt) begin tests_failed++; $display("FAIL bp_cnt got=%0d exp=%0d", frame_cnt, exp_cnt); end
    out_ready = 1'b1;
    repeat (2) @(negedge tick_in);
  endtask

  task automatic test_timeout;
    frame_t e;
    out_ready = 1'b1;
    put_byte(8'h02);
    // An accepted byte restarts the idle count, so 7 idle cycles here must not abort.
    for (int i = 0; i < TO - 1; i++) @(negedge tick_in);
    put_byte(8'hAA);
    for (int i = 0; i < TO; i++) begin
      #1;
      tests_run++;
      if ({byte_ready, err_pulse} !== 2'b10) begin
        tests_failed++; $display("FAIL to_idle cycle=%0d ready/pulse got=%b exp=10", i, {byte_ready, err_pulse});
      end
      @(negedge tick_in);
    end
    byte_in = 8'h01;
    byte_valid = 1'b1;
    #1;
    tests_run++;
    if (byte_ready !== 1'b0) begin tests_failed++; $display("FAIL to_ready_drop got=%b exp=0", byte_ready); end
    @(negedge tick_in);
    byte_valid = 1'b0;
    tests_run++;
    if ({err_pulse, err_code} !== 3'b110) begin
      tests_failed++; $display("FAIL to_err pulse/code got=%b exp=110", {err_pulse, err_code});
    end
    tests_run++;
    if (frame_cnt !== exp_cnt) begin tests_failed++; $display("FAIL to_cnt got=%0d exp=%0d", frame_cnt, exp_cnt); end
    build_frame(8'h01, 32'h13572468, 32'h9ABCDEF0);
    send_all(0);
    exp_cnt++;
    e = expect_frame(8'h01, 32'h13572468, 32'h9ABCDEF0);
    tests_run++;
    if ({out_op, out_key, out_value} !== e) begin
      tests_failed++; $display("FAIL to_recover got=%h exp=%h", {out_op, out_key, out_value}, e);
    end
    @(negedge tick_in);
  endtask

  task automatic test_reset_midframe;
    frame_t e;
    out_ready = 1'b0;
    build_frame(8'h02, 32'h0000FFFF, 32'hFFFF0000);
    send_all(0);
    put_byte(8'h01);
    put_byte(8'hAA);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({out_valid, out_op, out_key, out_value, err_pulse, err_code, frame_cnt} !== '0) begin
      tests_failed++; $display("FAIL rst_mid_outputs got=%h exp=0",
                               {out_valid, out_op, out_key, out_value, err_pulse, err_code, frame_cnt});
    end
    @(negedge tick_in);
    rst_n = 1'b1;
    exp_cnt = '0;
    out_ready = 1'b1;
    @(negedge tick_in);
    build_frame(8'h01, 32'h0BADF00D, 32'h12345678);
    send_all(0);
    exp_cnt++;
    e = expect_frame(8'h01, 32'h0BADF00D, 32'h12345678);
    tests_run++;
    if ({out_op, out_key, out_value} !== e || frame_cnt !== exp_cnt) begin
      tests_failed++; $display("FAIL rst_mid_recover got=%h cnt=%0d exp=%h cnt=%0d",
                               {out_op, out_key, out_value}, frame_cnt, e, exp_cnt);
    end
    @(negedge tick_in);
  endtask

`ifdef KV_CHECKSUM_EN
  task automatic test_checksum;
    out_ready = 1'b1;
    tx_q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h02};
    send_all(0);
    exp_cnt++;
    tests_run++;
    if ({out_valid, out_op, out_key, out_value} !== {1'b1, 2'd1, 32'h1, 32'h2}) begin
      tests_failed++; $display("FAIL csum_good got=%h exp=%h", {out_valid, out_op, out_key, out_value},
                               {1'b1, 2'd1, 32'h1, 32'h2});
    end
    @(negedge tick_in);
    tx_q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00};
    send_all(0);
    tests_run++;
    if ({err_pulse, err_code, out_valid} !== 4'b1110) begin
      tests_failed++; $display("FAIL csum_bad pulse/code/valid got=%b exp=1110", {err_pulse, err_code, out_valid});
    end
    tests_run++;
    if (frame_cnt !== exp_cnt) begin tests_failed++; $display("FAIL csum_cnt got=%0d exp=%0d", frame_cnt, exp_cnt); end
    @(negedge tick_in);
  endtask
`endif

  task automatic test_random;
    frame_t     exp_q[$];
    logic [1:0] exp_err[$];
    logic [7:0] opc, bad;
    logic [31:0] k, v;
    bit stop;
    stop = 0;
    got_q.delete();
    err_q.delete();
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          if ($urandom_range(0, 4) == 0) begin
            bad = 8'($urandom_range(0, 252));
            if (bad != 8'h00) bad = bad + 8'd3;
            put_byte(bad);
            exp_err.push_back(2'd1);
          end
          opc = 8'($urandom_range(1, 3));
          k = $urandom;
          v = $urandom;
          build_frame(opc, k, v);
          exp_q.push_back(expect_frame(opc, k, v));
          exp_cnt++;
          send_all(2);
        end
        stop = 1;
      end
      begin
        while (!stop) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(negedge tick_in);
        end
      end
    join
    out_ready = 1'b1;
    repeat (4) @(negedge tick_in);
    tests_run++;
    if (got_q.size() != exp_q.size()) begin
      tests_failed++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests_run++;
      if (got_q[i] !== exp_q[i]) begin
        tests_failed++; $display("FAIL rand_frame idx=%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    tests_run++;
    if (err_q.size() != exp_err.size()) begin
      tests_failed++; $display("FAIL rand_err_count got=%0d exp=%0d", err_q.size(), exp_err.size());
    end
    for (int i = 0; i < exp_err.size() && i < err_q.size(); i++) begin
      tests_run++;
      if (err_q[i] !== exp_err[i]) begin
        tests_failed++; $display("FAIL rand_err idx=%0d got=%0d exp=%0d", i, err_q[i], exp_err[i]);
      end
    end
    tests_run++;
    if (frame_cnt !== exp_cnt) begin tests_failed++; $display("FAIL rand_cnt got=%0d exp=%0d", frame_cnt, exp_cnt); end
  endtask

  initial begin
    test_reset();
    test_create();
    test_delete();
    test_bad_opcode();
    test_back_pressure();
    test_timeout();
`ifdef KV_CHECKSUM_EN
    test_checksum();
`endif
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
